// File: rtl/nf10_arb_pkg.sv
// Shared definitions for the five-input packet round-robin arbiter:
// queue count, FSM encoding and index helpers.
package nf10_arb_pkg;

    localparam int NUM_QUEUES = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    localparam int QUEUE_W = log2(NUM_QUEUES);

    typedef logic [QUEUE_W-1:0] queue_idx_t;

    // Next input in round-robin order, wrapping the last queue back to 0.
    function automatic queue_idx_t rr_next(input queue_idx_t idx);
        return (idx == queue_idx_t'(NUM_QUEUES - 1)) ? '0 : idx + queue_idx_t'(1);
    endfunction

endpackage

// File: rtl/nf10_arb_in_fifo.sv
// Per-input elastic FIFO: synchronous write, fallthrough head (dout shows the
// oldest entry whenever empty is low), asynchronous active-low reset.
module nf10_arb_in_fifo #(
    parameter int WIDTH      = 417,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   FULL_LEVEL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   NF_LEVEL   = (DEPTH_BITS + 1)'(DEPTH - 1);
    localparam logic [DEPTH_BITS:0]   CNT_ONE    = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && (count_q != FULL_LEVEL);
        do_rd    = rd_en && (count_q != '0);
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout        = mem_q[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= NF_LEVEL);

endmodule

// File: rtl/nf10_rr_input_arbiter.sv
// Five AXI4-Stream inputs merged into one output, round-robin per packet;
// a granted input keeps the output until its tlast beat is accepted.
module nf10_rr_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 5,
    parameter int FIFO_DEPTH_BITS      = 4
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                              s_axis_tvalid_0,
    output logic                              s_axis_tready_0,
    input  logic                              s_axis_tlast_0,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                              s_axis_tvalid_1,
    output logic                              s_axis_tready_1,
    input  logic                              s_axis_tlast_1,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
    input  logic                              s_axis_tvalid_2,
    output logic                              s_axis_tready_2,
    input  logic                              s_axis_tlast_2,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
    input  logic                              s_axis_tvalid_3,
    output logic                              s_axis_tready_3,
    input  logic                              s_axis_tlast_3,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_4,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_4,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_4,
    input  logic                              s_axis_tvalid_4,
    output logic                              s_axis_tready_4,
    input  logic                              s_axis_tlast_4,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    import nf10_arb_pkg::*;

    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int FIFO_W = 1 + SW + UW + DW;

    logic [FIFO_W-1:0]     fifo_din  [NUM_QUEUES];
    logic [FIFO_W-1:0]     fifo_dout [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] s_tvalid;
    logic [NUM_QUEUES-1:0] s_tready;
    logic [NUM_QUEUES-1:0] wr_en;
    logic [NUM_QUEUES-1:0] rd_en;
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] nearly_full;

    arb_state_e  state_q, state_d;
    queue_idx_t  cur_queue_q, cur_queue_d;
    queue_idx_t  rr_ptr_q, rr_ptr_d;
    queue_idx_t  scan_idx;
    logic        found;
    logic        ready_en_q;
    logic [FIFO_W-1:0] head;
    logic        head_last;
    logic        out_fire;

    assign fifo_din[0] = {s_axis_tlast_0, s_axis_tstrb_0, s_axis_tuser_0, s_axis_tdata_0};
    assign fifo_din[1] = {s_axis_tlast_1, s_axis_tstrb_1, s_axis_tuser_1, s_axis_tdata_1};
    assign fifo_din[2] = {s_axis_tlast_2, s_axis_tstrb_2, s_axis_tuser_2, s_axis_tdata_2};
    assign fifo_din[3] = {s_axis_tlast_3, s_axis_tstrb_3, s_axis_tuser_3, s_axis_tdata_3};
    assign fifo_din[4] = {s_axis_tlast_4, s_axis_tstrb_4, s_axis_tuser_4, s_axis_tdata_4};

    assign s_tvalid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                       s_axis_tvalid_1, s_axis_tvalid_0};

    // Hold tready low until the first clock after reset release.
    assign s_tready = ready_en_q ? ~nearly_full : '0;

    assign s_axis_tready_0 = s_tready[0];
    assign s_axis_tready_1 = s_tready[1];
    assign s_axis_tready_2 = s_tready[2];
    assign s_axis_tready_3 = s_tready[3];
    assign s_axis_tready_4 = s_tready[4];

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
        nf10_arb_in_fifo #(
            .WIDTH      (FIFO_W),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk         (axi_aclk),
            .rst_n       (axi_resetn),
            .din         (fifo_din[g]),
            .wr_en       (wr_en[g]),
            .rd_en       (rd_en[g]),
            .dout        (fifo_dout[g]),
            .empty       (empty[g]),
            .nearly_full (nearly_full[g])
        );
    end

    assign head          = fifo_dout[cur_queue_q];
    assign head_last     = head[FIFO_W-1];
    assign m_axis_tdata  = head[DW-1:0];
    assign m_axis_tuser  = head[DW +: UW];
    assign m_axis_tstrb  = head[DW+UW +: SW];
    assign m_axis_tlast  = head_last;
    assign m_axis_tvalid = (state_q == SEND) && !empty[cur_queue_q];
    assign out_fire      = m_axis_tvalid && m_axis_tready;

    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            wr_en[i] = s_tvalid[i] && s_tready[i];
            rd_en[i] = out_fire && (cur_queue_q == queue_idx_t'(i));
        end
    end

    // Grant scan starts at rr_ptr and visits every input once.
    always_comb begin
        state_d     = state_q;
        cur_queue_d = cur_queue_q;
        rr_ptr_d    = rr_ptr_q;
        scan_idx    = rr_ptr_q;
        found       = 1'b0;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_QUEUES; i++) begin
                    if (!found && !empty[scan_idx]) begin
                        found       = 1'b1;
                        cur_queue_d = scan_idx;
                    end
                    scan_idx = rr_next(scan_idx);
                end
                if (found) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_fire && head_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = rr_next(cur_queue_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= IDLE;
            cur_queue_q <= '0;
            rr_ptr_q    <= '0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_queue_q <= cur_queue_d;
            rr_ptr_q    <= rr_ptr_d;
            ready_en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Bench for nf10_rr_input_arbiter: packet queues plus a grant/round-robin
// reference, compared against the DUT on every clock.
module tb_nf10_rr_input_arbiter;

    localparam int DW    = 256;
    localparam int SW    = 32;
    localparam int UW    = 128;
    localparam int NQ    = 5;
    localparam int DEPTH = 16;

    logic axi_aclk = 1'b0;
    logic axi_resetn = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    logic [DW-1:0] s_tdata  [NQ];
    logic [SW-1:0] s_tstrb  [NQ];
    logic [UW-1:0] s_tuser  [NQ];
    logic          s_tvalid [NQ];
    logic          s_tready [NQ];
    logic          s_tlast  [NQ];
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    nf10_rr_input_arbiter dut (
        .axi_aclk        (axi_aclk),
        .axi_resetn      (axi_resetn),
        .s_axis_tdata_0  (s_tdata[0]),  .s_axis_tstrb_0 (s_tstrb[0]), .s_axis_tuser_0 (s_tuser[0]),
        .s_axis_tvalid_0 (s_tvalid[0]), .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0 (s_tlast[0]),
        .s_axis_tdata_1  (s_tdata[1]),  .s_axis_tstrb_1 (s_tstrb[1]), .s_axis_tuser_1 (s_tuser[1]),
        .s_axis_tvalid_1 (s_tvalid[1]), .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1 (s_tlast[1]),
        .s_axis_tdata_2  (s_tdata[2]),  .s_axis_tstrb_2 (s_tstrb[2]), .s_axis_tuser_2 (s_tuser[2]),
        .s_axis_tvalid_2 (s_tvalid[2]), .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2 (s_tlast[2]),
        .s_axis_tdata_3  (s_tdata[3]),  .s_axis_tstrb_3 (s_tstrb[3]), .s_axis_tuser_3 (s_tuser[3]),
        .s_axis_tvalid_3 (s_tvalid[3]), .s_axis_tready_3(s_tready[3]), .s_axis_tlast_3 (s_tlast[3]),
        .s_axis_tdata_4  (s_tdata[4]),  .s_axis_tstrb_4 (s_tstrb[4]), .s_axis_tuser_4 (s_tuser[4]),
        .s_axis_tvalid_4 (s_tvalid[4]), .s_axis_tready_4(s_tready[4]), .s_axis_tlast_4 (s_tlast[4]),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tstrb    (m_axis_tstrb),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        int            gap;
    } beat_t;

    beat_t src [NQ][$];     // beats still to be offered by each upstream source
    beat_t fq  [NQ][$];     // beats held by each input FIFO
    int    locked;          // input owning the output, -1 when none
    int    rr;
    bit    ready_en;

    int vectors, miscompares, cyc;
    bit rand_valid, rand_ready, ready_fixed, track_full;
    int dut_order[$];
    int first_acc, first_val, last_done, out_beats, nf_at;
    int acc_cnt [NQ];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready(input int i);
        return ready_en && (fq[i].size() < DEPTH - 1);
    endfunction

    task automatic make_packet(input int port, input int n, input int gap_at, input int gap_len);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
            b.data[DW-1 -: 8] = 8'(port);
            b.strb = $urandom;
            for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
            b.last = (k == n - 1);
            b.gap  = (k == gap_at) ? gap_len : 0;
            src[port].push_back(b);
        end
    endtask

    task automatic drive_idle();
        for (int i = 0; i < NQ; i++) begin
            s_tvalid[i] = 1'b0;
            s_tdata[i]  = '0;
            s_tstrb[i]  = '0;
            s_tuser[i]  = '0;
            s_tlast[i]  = 1'b0;
        end
    endtask

    task automatic clear_track();
        dut_order.delete();
        first_acc = -1;
        first_val = -1;
        last_done = -1;
        out_beats = 0;
    endtask

    task automatic step();
        beat_t h;
        bit    exp_valid;
        bit    acc [NQ];
        beat_t newb [NQ];
        bit    got;
        int    p;
        @(negedge axi_aclk);
        exp_valid = (locked >= 0) && (fq[locked].size() > 0);
        chk("m_tvalid", DW'(m_axis_tvalid), DW'(exp_valid));
        if (exp_valid) begin
            h = fq[locked][0];
            chk("m_tdata", m_axis_tdata, h.data);
            chk("m_tstrb", DW'(m_axis_tstrb), DW'(h.strb));
            chk("m_tuser", DW'(m_axis_tuser), DW'(h.user));
            chk("m_tlast", DW'(m_axis_tlast), DW'(h.last));
        end
        for (int i = 0; i < NQ; i++)
            chk($sformatf("s_tready_%0d", i), DW'(s_tready[i]), DW'(model_ready(i)));
        if (m_axis_tvalid && first_val < 0) first_val = cyc;
        if (track_full && nf_at < 0 && !s_tready[0]) nf_at = acc_cnt[0];

        m_axis_tready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
        drive_idle();
        for (int i = 0; i < NQ; i++) begin
            acc[i] = 1'b0;
            if (src[i].size() > 0) begin
                h = src[i][0];
                if (h.gap > 0) begin
                    h.gap = h.gap - 1;
                    src[i][0] = h;
                end else if (!rand_valid || $urandom_range(0, 3) != 0) begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i]  = h.data;
                    s_tstrb[i]  = h.strb;
                    s_tuser[i]  = h.user;
                    s_tlast[i]  = h.last;
                    if (model_ready(i)) begin
                        acc[i]  = 1'b1;
                        newb[i] = src[i].pop_front();
                        acc_cnt[i]++;
                        if (first_acc < 0) first_acc = cyc;
                    end
                end
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            out_beats++;
            if (m_axis_tlast) begin
                dut_order.push_back(int'(m_axis_tdata[DW-1 -: 8]));
                last_done = cyc;
            end
        end

        // Reference: grant/read decisions use occupancy before this edge's writes.
        if (locked >= 0) begin
            if (fq[locked].size() > 0 && m_axis_tready) begin
                h = fq[locked].pop_front();
                if (h.last) begin
                    rr = (locked + 1) % NQ;
                    locked = -1;
                end
            end
        end else begin
            got = 1'b0;
            for (int k = 0; k < NQ; k++) begin
                p = (rr + k) % NQ;
                if (!got && fq[p].size() > 0) begin
                    got = 1'b1;
                    locked = p;
                end
            end
        end
        for (int i = 0; i < NQ; i++)
            if (acc[i]) fq[i].push_back(newb[i]);
        cyc++;
    endtask

    function automatic bit busy();
        bit b;
        b = (locked >= 0);
        for (int i = 0; i < NQ; i++)
            if (src[i].size() > 0 || fq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while (busy() && n < max_cyc) begin
            step();
            n++;
        end
        if (busy()) chk({name, "_timeout"}, DW'(1), DW'(0));
    endtask

    task automatic apply_reset(input int n);
        @(negedge axi_aclk);
        axi_resetn    = 1'b0;
        m_axis_tready = 1'b0;
        drive_idle();
        for (int i = 0; i < NQ; i++) begin
            src[i].delete();
            fq[i].delete();
        end
        locked   = -1;
        rr       = 0;
        ready_en = 1'b0;
        #1;
        chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        for (int i = 0; i < NQ; i++) chk($sformatf("rst_tready_%0d", i), DW'(s_tready[i]), DW'(0));
        repeat (n) begin
            @(negedge axi_aclk);
            chk("rst_hold_m_tvalid", DW'(m_axis_tvalid), DW'(0));
            for (int i = 0; i < NQ; i++) chk($sformatf("rst_hold_tready_%0d", i), DW'(s_tready[i]), DW'(0));
            cyc++;
        end
        axi_resetn = 1'b1;
        ready_en   = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p;
        vectors = 0; miscompares = 0; cyc = 0;
        rand_valid = 0; rand_ready = 0; ready_fixed = 1; track_full = 0; nf_at = -1;
        locked = -1; rr = 0; ready_en = 0;
        for (int i = 0; i < NQ; i++) acc_cnt[i] = 0;
        m_axis_tready = 1'b0;
        drive_idle();
        apply_reset(3);

        // Five 2-beat packets present at once, starting from rr_ptr 0.
        clear_track();
        for (int i = 0; i < NQ; i++) make_packet(i, 2, -1, 0);
        wait_idle("all5", 200);
        chk("all5_count", DW'(dut_order.size()), DW'(5));
        for (int i = 0; i < dut_order.size(); i++) chk("all5_order", DW'(dut_order[i]), DW'(i));
        chk("all5_span", DW'(last_done - first_val), DW'(13));

        // Single 3-beat packet on port 2.
        clear_track();
        make_packet(2, 3, -1, 0);
        wait_idle("single", 100);
        chk("single_latency", DW'(first_val - first_acc), DW'(2));
        chk("single_beats", DW'(out_beats), DW'(3));
        chk("single_span", DW'(last_done - first_val), DW'(2));

        // One-beat packets on ports 4 and 0, rr_ptr now 3.
        clear_track();
        make_packet(4, 1, -1, 0); make_packet(4, 1, -1, 0);
        make_packet(0, 1, -1, 0); make_packet(0, 1, -1, 0);
        wait_idle("wrap", 100);
        chk("wrap_count", DW'(dut_order.size()), DW'(4));
        for (int i = 0; i < dut_order.size(); i++)
            chk("wrap_order", DW'(dut_order[i]), DW'((i % 2 == 0) ? 4 : 0));

        // Port 1 stalls 5 cycles mid-packet while port 3 waits.
        clear_track();
        make_packet(1, 4, 2, 5);
        make_packet(3, 2, -1, 0);
        wait_idle("stall", 100);
        chk("stall_count", DW'(dut_order.size()), DW'(2));
        if (dut_order.size() == 2) begin
            chk("stall_first", DW'(dut_order[0]), DW'(1));
            chk("stall_second", DW'(dut_order[1]), DW'(3));
        end

        // Output blocked: port 0 fills to the nearly-full level.
        clear_track();
        ready_fixed = 0; track_full = 1; nf_at = -1; acc_cnt[0] = 0;
        make_packet(0, 20, -1, 0);
        repeat (40) step();
        chk("fill_tready_drop_at", DW'(nf_at), DW'(15));
        chk("fill_accepted", DW'(acc_cnt[0]), DW'(15));
        ready_fixed = 1; track_full = 0;
        wait_idle("fill", 200);
        chk("fill_out_beats", DW'(out_beats), DW'(20));
        chk("fill_packets", DW'(dut_order.size()), DW'(1));

        // Random traffic with random source and sink throttling.
        rand_valid = 1; rand_ready = 1;
        repeat (1500) begin
            if ($urandom_range(0, 4) == 0) begin
                p = $urandom_range(0, NQ - 1);
                if (src[p].size() < 24)
                    make_packet(p, $urandom_range(1, 6),
                                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
                                $urandom_range(1, 4));
            end
            step();
        end
        rand_valid = 0; rand_ready = 0; ready_fixed = 1;
        wait_idle("random", 3000);

        // Reset asserted mid-packet on port 3.
        clear_track();
        make_packet(3, 6, -1, 0);
        n = 0;
        while (out_beats < 2 && n < 60) begin
            step();
            n++;
        end
        chk("midrst_reached", DW'(out_beats >= 2), DW'(1));
        apply_reset(1);
        clear_track();
        make_packet(4, 1, -1, 0);
        make_packet(1, 1, -1, 0);
        wait_idle("postrst", 100);
        chk("postrst_count", DW'(dut_order.size()), DW'(2));
        if (dut_order.size() == 2) begin
            chk("postrst_first", DW'(dut_order[0]), DW'(1));
            chk("postrst_second", DW'(dut_order[1]), DW'(4));
        end
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nf10_rr_input_arbiter.md
# nf10_rr_input_arbiter

Merges five AXI4-Stream slave inputs into one AXI4-Stream master output with packet-granular round-robin arbitration. It is the ingress-side counterpart of the BRAM output queues. It collects packets from the MAC/DMA receive paths and feeds the single datapath stream that later fans back out. Each input has a small elastic FIFO. The arbiter never interleaves beats of different packets.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, output tdata width
- C_S_AXIS_DATA_WIDTH, 256, input tdata width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width; must equal C_M_AXIS_TUSER_WIDTH
- NUM_QUEUES, 5, number of inputs; ports are fixed at 5
- FIFO_DEPTH_BITS, 4, log2 of per-input FIFO depth in beats (16)

Ports:
- axi_aclk  in  1  single clock
- axi_resetn  in  1  asynchronous active-low reset
- s_axis_tdata_0..4  in  C_S_AXIS_DATA_WIDTH  input data, per port
- s_axis_tstrb_0..4  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
- s_axis_tuser_0..4  in  C_S_AXIS_TUSER_WIDTH  metadata, meaningful on first beat
- s_axis_tvalid_0..4  in  1  beat valid
- s_axis_tready_0..4  out  1  beat accepted when tvalid & tready
- s_axis_tlast_0..4  in  1  last beat of packet
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  merged data
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  merged strobes
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  merged metadata
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat

## Operation
- Per-input FIFO:
  - Stores {tlast, tstrb, tuser, tdata}.
  - s_axis_tready_N = ~nearly_full_N, where nearly_full means count ≥ depth-1.
  - A write occurs on s_axis_tvalid_N & s_axis_tready_N.
- FSM has two states, IDLE and SEND; encoding is IDLE=0, SEND=1.
- IDLE:
  - Scan the inputs starting at rr_ptr, wrapping 4→0.
  - Select the first input with a non-empty FIFO, register cur_queue, and go to SEND.
  - If all FIFOs are empty, stay in IDLE.
- SEND:
  - m_axis_tvalid = ~empty[cur_queue].
  - Output data, strobe, user and last are taken from the head of FIFO cur_queue.
  - FIFO read occurs on m_axis_tvalid & m_axis_tready.
  - On an accepted beat with tlast: go to IDLE, and set rr_ptr = (cur_queue+1) wrapping 4→0.
- Arbitration is locked for the whole packet. If the selected FIFO runs empty mid-packet, m_axis_tvalid drops and the arbiter waits on that FIFO. It never switches input.
- Several requesting inputs are served strictly in round-robin order from rr_ptr.
- A single-beat packet (tlast on its first beat) is legal. It completes SEND in one accepted beat.
- tuser is passed through on every beat. Downstream treats it as valid on the first beat only.

## Timing
- Reset values:
  - All s_axis_tready low during reset. After release they rise on the first clock, because the FIFOs are empty.
  - m_axis_tvalid 0.
  - state IDLE, rr_ptr 0, cur_queue 0, all FIFOs empty.
  - Data outputs: don't-care.
- Latency when idle: a beat written in cycle t is at the FIFO head in t+1. The arbiter selects in t+1, and m_axis_tvalid is asserted in t+2.
- Inter-packet gap: exactly one IDLE cycle after each accepted tlast beat. Throughput is N/(N+1) for back-to-back N-beat packets.
- m_axis_tvalid never depends combinationally on m_axis_tready. Once asserted, data is held stable until accepted.
- A simultaneous FIFO write and read on the same input in the same cycle leaves the count unchanged. That input's tready is unaffected.
- Reset asserted mid-packet: everything clears immediately and asynchronously, and partial packets are discarded. Upstream retransmission is outside this block.

## Structure
- Shared package nf10_arb_pkg holds:
  - NUM_QUEUES
  - the state encodings IDLE/SEND
  - the log2 function
  - a helper for the round-robin next-index wrap
- Sub-module nf10_arb_in_fifo, instantiated 5×:
  - synchronous-read fallthrough FIFO with asynchronous active-low reset
  - outputs dout, empty, nearly_full

## Test plan
- Single 3-beat packet on port 2, m_axis_tready=1 → output tvalid from cycle t+2 for 3 consecutive cycles; tlast on the third beat; data and tuser match the input.
- All five ports each hold one 2-beat packet at once, rr_ptr=0 → output order is ports 0,1,2,3,4, with one idle cycle between packets; no interleaving.
- Port 1 stalls mid-packet (tvalid low for 5 cycles) while port 3 has a packet waiting → m_axis_tvalid is low for those cycles; port 3 starts only after port 1's tlast.
- Hold m_axis_tready=0 and stream 20 beats into port 0 → s_axis_tready_0 falls after 15 beats accepted; no beat is lost or duplicated after tready is restored.
- One-beat packets alternating on ports 4 and 0 → rr_ptr wraps 4→0 and service alternates 4,0,4,0.
- Assert axi_resetn=0 for 1 cycle mid-packet on port 3 → m_axis_tvalid is 0 immediately, FIFOs are empty, and the next packet on any port is forwarded cleanly starting from rr_ptr=0.
